// File: rtl/pmem_pkg.sv
// Shared definitions for the program-memory front end: FSM state encodings
// and line/index width helpers.
package pmem_pkg;

    typedef logic [1:0] pmem_state_t;

    localparam pmem_state_t PMEM_IDLE      = 2'd0;
    localparam pmem_state_t PMEM_WAITING   = 2'd1;
    localparam pmem_state_t PMEM_RELAYING  = 2'd2;
    localparam pmem_state_t PMEM_RELEASING = 2'd3;

    function automatic int line_bits(input int read_num, input int data_bits);
        return read_num * data_bits;
    endfunction

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: highest priority goes to the index just
// after last_grant, wrapping around through last_grant itself.
module rr_arbiter
    import pmem_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = idx_bits(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] last_grant,
    output logic          grant_valid,
    output logic [IW-1:0] grant_index
);

    int idx;

    // Scan from the farthest candidate to the nearest so the nearest hit wins.
    always_comb begin
        grant_valid = 1'b0;
        grant_index = '0;
        idx         = 0;
        for (int k = N; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % N;
            if (req[idx]) begin
                grant_valid = 1'b1;
                grant_index = idx[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/program_mem_controller.sv
// Round-robin program-memory line fetcher shared by several instruction fetchers.
// Define PMEM_COALESCE_EN to also deliver each line to other same-address waiters.
//
// state          | meaning
// ---------------+-----------------------------------------------------------
// PMEM_IDLE      | no read outstanding; grant the next requester round-robin
// PMEM_WAITING   | external read issued; wait for mem_read_ready
// PMEM_RELAYING  | one-cycle ready/data pulse to every consumer in serve_mask
// PMEM_RELEASING | wait for all served consumers to drop their valid
module program_mem_controller
    import pmem_pkg::*;
#(
    parameter int NUM_CONSUMERS = 4,
    parameter int ADDR_BITS     = 8,
    parameter int DATA_BITS     = 16,
    parameter int READ_NUM      = 4,
    localparam int LINE_BITS    = line_bits(READ_NUM, DATA_BITS),
    localparam int IDX_BITS     = idx_bits(NUM_CONSUMERS)
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [NUM_CONSUMERS-1:0]            consumer_read_valid,
    input  logic [NUM_CONSUMERS*ADDR_BITS-1:0]  consumer_read_address,
    output logic [NUM_CONSUMERS-1:0]            consumer_read_ready,
    output logic [NUM_CONSUMERS*LINE_BITS-1:0]  consumer_read_data,
    output logic                                mem_read_valid,
    output logic [ADDR_BITS-1:0]                mem_read_address,
    input  logic                                mem_read_ready,
    input  logic [LINE_BITS-1:0]                mem_read_data
);

    pmem_state_t              state;
    logic [IDX_BITS-1:0]      rr_ptr;
    logic [IDX_BITS-1:0]      last_grant;
    logic [IDX_BITS-1:0]      grant_idx;
    logic [IDX_BITS-1:0]      arb_index;
    logic [IDX_BITS-1:0]      next_ptr;
    logic                     arb_valid;
    logic [ADDR_BITS-1:0]     sel_addr;
    logic [LINE_BITS-1:0]     line_reg;
    logic [NUM_CONSUMERS-1:0] serve_mask;
    logic [NUM_CONSUMERS-1:0] match_mask;

    // rr_ptr holds the next index to try first; the arbiter wants the one before it.
    assign last_grant = (rr_ptr == '0) ? IDX_BITS'(NUM_CONSUMERS - 1)
                                       : rr_ptr - IDX_BITS'(1);
    assign next_ptr   = (arb_index == IDX_BITS'(NUM_CONSUMERS - 1)) ? '0
                                       : arb_index + IDX_BITS'(1);
    assign sel_addr   = consumer_read_address[arb_index*ADDR_BITS +: ADDR_BITS];

    rr_arbiter #(
        .N (NUM_CONSUMERS)
    ) u_rr_arbiter (
        .req         (consumer_read_valid),
        .last_grant  (last_grant),
        .grant_valid (arb_valid),
        .grant_index (arb_index)
    );

    always_comb begin
        match_mask            = '0;
        match_mask[grant_idx] = 1'b1;
`ifdef PMEM_COALESCE_EN
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (consumer_read_valid[i] &&
                consumer_read_address[i*ADDR_BITS +: ADDR_BITS] == mem_read_address)
                match_mask[i] = 1'b1;
        end
`endif
    end

    assign consumer_read_ready = (state == PMEM_RELAYING) ? serve_mask : '0;

    always_comb begin
        consumer_read_data = '0;
        for (int i = 0; i < NUM_CONSUMERS; i++) begin
            if (consumer_read_ready[i])
                consumer_read_data[i*LINE_BITS +: LINE_BITS] = line_reg;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state            <= PMEM_IDLE;
            rr_ptr           <= '0;
            grant_idx        <= '0;
            mem_read_valid   <= 1'b0;
            mem_read_address <= '0;
            line_reg         <= '0;
            serve_mask       <= '0;
        end else begin
            case (state)
                PMEM_IDLE: begin
                    if (arb_valid) begin
                        grant_idx        <= arb_index;
                        rr_ptr           <= next_ptr;
                        mem_read_address <= sel_addr;
                        mem_read_valid   <= 1'b1;
                        state            <= PMEM_WAITING;
                    end
                end
                PMEM_WAITING: begin
                    if (mem_read_ready) begin
                        line_reg       <= mem_read_data;
                        mem_read_valid <= 1'b0;
                        serve_mask     <= match_mask;
                        state          <= PMEM_RELAYING;
                    end
                end
                PMEM_RELAYING: begin
                    state <= PMEM_RELEASING;
                end
                PMEM_RELEASING: begin
                    if ((consumer_read_valid & serve_mask) == '0)
                        state <= PMEM_IDLE;
                end
                default: begin
                    state <= PMEM_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_program_mem_controller.sv
// Directed self-checking bench for program_mem_controller (default parameters).
module tb_program_mem_controller;

    logic         clk;
    logic         reset;
    logic [3:0]   c_valid;
    logic [31:0]  c_addr;
    logic [3:0]   c_ready;
    logic [255:0] c_data;
    logic         mem_read_valid;
    logic [7:0]   mem_read_address;
    logic         mem_read_ready;
    logic [63:0]  mem_read_data;

    int vectors;
    int miscompares;

    program_mem_controller dut (
        .clk                   (clk),
        .reset                 (reset),
        .consumer_read_valid   (c_valid),
        .consumer_read_address (c_addr),
        .consumer_read_ready   (c_ready),
        .consumer_read_data    (c_data),
        .mem_read_valid        (mem_read_valid),
        .mem_read_address      (mem_read_address),
        .mem_read_ready        (mem_read_ready),
        .mem_read_data         (mem_read_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        reset          = 1'b1;
        c_valid        = '0;
        c_addr         = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        vectors++;
        if (mem_read_valid !== 1'b0) begin
            $display("FAIL reset_mem_valid got %b want 0", mem_read_valid); miscompares++;
        end
        vectors++;
        if (mem_read_address !== 8'h00) begin
            $display("FAIL reset_mem_addr got %h want 00", mem_read_address); miscompares++;
        end
        vectors++;
        if (c_ready !== 4'b0000 || c_data !== '0) begin
            $display("FAIL reset_consumer got ready=%b data=%h want 0", c_ready, c_data); miscompares++;
        end
    endtask

    task automatic test_single();
        logic [63:0] line;
        line = 64'h1111_2222_3333_4444;
        apply_reset();
        c_valid[2]    = 1'b1;
        c_addr[16+:8] = 8'h10;
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h10) begin
            $display("FAIL single_issue got v=%b a=%h want v=1 a=10", mem_read_valid, mem_read_address);
            miscompares++;
        end
        tick();
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || c_ready !== 4'b0000) begin
            $display("FAIL single_hold got v=%b rdy=%b want v=1 rdy=0000", mem_read_valid, c_ready);
            miscompares++;
        end
        tick();
        mem_read_ready = 1'b1;
        mem_read_data  = line;
        tick();
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        vectors++;
        if (c_ready !== 4'b0100 || mem_read_valid !== 1'b0) begin
            $display("FAIL single_ready got rdy=%b v=%b want rdy=0100 v=0", c_ready, mem_read_valid);
            miscompares++;
        end
        vectors++;
        if (c_data[128+:64] !== line || c_data[0+:128] !== '0 || c_data[192+:64] !== '0) begin
            $display("FAIL single_data got %h want %h in slot 2 only", c_data, line);
            miscompares++;
        end
        c_valid[2] = 1'b0;
        tick();
        vectors++;
        if (c_ready !== 4'b0000 || c_data !== '0) begin
            $display("FAIL single_pulse got rdy=%b want 0000", c_ready); miscompares++;
        end
        tick();
    endtask

    task automatic test_all_four();
        logic [63:0] line;
        apply_reset();
        c_valid = 4'b1111;
        c_addr  = {8'h43, 8'h42, 8'h41, 8'h40};
        for (int k = 0; k < 4; k++) begin
            tick();
            vectors++;
            if (mem_read_valid !== 1'b1 || mem_read_address !== 8'(8'h40 + k)) begin
                $display("FAIL rr_order_%0d got v=%b a=%h want v=1 a=%h",
                         k, mem_read_valid, mem_read_address, 8'(8'h40 + k));
                miscompares++;
            end
            line           = {16'(k), 16'hA5A5, 16'(k), 16'h5A5A};
            mem_read_ready = 1'b1;
            mem_read_data  = line;
            tick();
            mem_read_ready = 1'b0;
            vectors++;
            if (c_ready !== 4'(1 << k) || c_data[k*64+:64] !== line) begin
                $display("FAIL rr_serve_%0d got rdy=%b data=%h want rdy=%b data=%h",
                         k, c_ready, c_data[k*64+:64], 4'(1 << k), line);
                miscompares++;
            end
            c_valid[k] = 1'b0;
            tick();
            tick();
        end
        tick();
        vectors++;
        if (mem_read_valid !== 1'b0) begin
            $display("FAIL rr_done got v=%b want 0", mem_read_valid); miscompares++;
        end
    endtask

    task automatic test_same_address();
        logic [63:0] line;
        line = 64'hCAFE_F00D_DEAD_BEEF;
        apply_reset();
        c_valid       = 4'b1010;
        c_addr[8+:8]  = 8'h20;
        c_addr[24+:8] = 8'h20;
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h20) begin
            $display("FAIL same_issue1 got v=%b a=%h want v=1 a=20", mem_read_valid, mem_read_address);
            miscompares++;
        end
        mem_read_ready = 1'b1;
        mem_read_data  = line;
        tick();
        mem_read_ready = 1'b0;
`ifdef PMEM_COALESCE_EN
        vectors++;
        if (c_ready !== 4'b1010 || c_data[64+:64] !== line || c_data[192+:64] !== line) begin
            $display("FAIL same_coalesce got rdy=%b want 1010 with both lines", c_ready);
            miscompares++;
        end
        c_valid = 4'b0000;
        tick();
        tick();
        tick();
        vectors++;
        if (mem_read_valid !== 1'b0) begin
            $display("FAIL same_no_second got v=%b want 0", mem_read_valid); miscompares++;
        end
`else
        vectors++;
        if (c_ready !== 4'b0010 || c_data[64+:64] !== line || c_data[192+:64] !== '0) begin
            $display("FAIL same_first got rdy=%b want 0010", c_ready); miscompares++;
        end
        c_valid[1] = 1'b0;
        tick();
        tick();
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h20) begin
            $display("FAIL same_issue2 got v=%b a=%h want v=1 a=20", mem_read_valid, mem_read_address);
            miscompares++;
        end
        mem_read_ready = 1'b1;
        tick();
        mem_read_ready = 1'b0;
        vectors++;
        if (c_ready !== 4'b1000 || c_data[192+:64] !== line) begin
            $display("FAIL same_second got rdy=%b want 1000", c_ready); miscompares++;
        end
        c_valid[3] = 1'b0;
        tick();
        tick();
`endif
    endtask

    task automatic test_reset_mid_wait();
        apply_reset();
        c_valid[2]    = 1'b1;
        c_addr[16+:8] = 8'h55;
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h55) begin
            $display("FAIL rstwait_issue got v=%b a=%h want v=1 a=55", mem_read_valid, mem_read_address);
            miscompares++;
        end
        reset   = 1'b1;
        c_valid = '0;
        tick();
        reset = 1'b0;
        vectors++;
        if (mem_read_valid !== 1'b0 || mem_read_address !== 8'h00 || c_ready !== 4'b0000) begin
            $display("FAIL rstwait_clear got v=%b a=%h rdy=%b want 0/00/0000",
                     mem_read_valid, mem_read_address, c_ready);
            miscompares++;
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 64'h0123_4567_89AB_CDEF;
        tick();
        mem_read_ready = 1'b0;
        tick();
        vectors++;
        if (c_ready !== 4'b0000 || mem_read_valid !== 1'b0) begin
            $display("FAIL rstwait_stale got rdy=%b v=%b want 0000/0", c_ready, mem_read_valid);
            miscompares++;
        end
        c_valid       = 4'b1001;
        c_addr[0+:8]  = 8'h30;
        c_addr[24+:8] = 8'h33;
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h30) begin
            $display("FAIL rstwait_ptr got v=%b a=%h want v=1 a=30", mem_read_valid, mem_read_address);
            miscompares++;
        end
    endtask

    task automatic test_hold_valid();
        apply_reset();
        c_valid       = 4'b0110;
        c_addr[8+:8]  = 8'h60;
        c_addr[16+:8] = 8'h61;
        tick();
        vectors++;
        if (mem_read_address !== 8'h60) begin
            $display("FAIL hold_issue got a=%h want 60", mem_read_address); miscompares++;
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 64'h6060_6060_6060_6060;
        tick();
        mem_read_ready = 1'b0;
        vectors++;
        if (c_ready !== 4'b0010) begin
            $display("FAIL hold_ready got rdy=%b want 0010", c_ready); miscompares++;
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            vectors++;
            if (mem_read_valid !== 1'b0 || c_ready !== 4'b0000) begin
                $display("FAIL hold_block_%0d got v=%b rdy=%b want 0/0000", k, mem_read_valid, c_ready);
                miscompares++;
            end
        end
        c_valid[1] = 1'b0;
        tick();
        vectors++;
        if (mem_read_valid !== 1'b0) begin
            $display("FAIL hold_idle got v=%b want 0", mem_read_valid); miscompares++;
        end
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h61) begin
            $display("FAIL hold_next got v=%b a=%h want v=1 a=61", mem_read_valid, mem_read_address);
            miscompares++;
        end
    endtask

    task automatic test_back_to_back();
        apply_reset();
        c_valid[0]   = 1'b1;
        c_addr[0+:8] = 8'h70;
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h70) begin
            $display("FAIL b2b_t1 got v=%b a=%h want v=1 a=70", mem_read_valid, mem_read_address);
            miscompares++;
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 64'h7070_7070_7070_7070;
        tick();
        mem_read_ready = 1'b0;
        vectors++;
        if (c_ready !== 4'b0001 || c_data[0+:64] !== 64'h7070_7070_7070_7070) begin
            $display("FAIL b2b_t2 got rdy=%b want 0001", c_ready); miscompares++;
        end
        c_valid      = 4'b0010;
        c_addr[8+:8] = 8'h71;
        tick();
        tick();
        vectors++;
        if (mem_read_valid !== 1'b0) begin
            $display("FAIL b2b_t4 got v=%b want 0", mem_read_valid); miscompares++;
        end
        tick();
        vectors++;
        if (mem_read_valid !== 1'b1 || mem_read_address !== 8'h71) begin
            $display("FAIL b2b_t5 got v=%b a=%h want v=1 a=71", mem_read_valid, mem_read_address);
            miscompares++;
        end
        mem_read_ready = 1'b1;
        mem_read_data  = 64'h7171_7171_7171_7171;
        tick();
        mem_read_ready = 1'b0;
        vectors++;
        if (c_ready !== 4'b0010 || c_data[64+:64] !== 64'h7171_7171_7171_7171) begin
            $display("FAIL b2b_second got rdy=%b want 0010", c_ready); miscompares++;
        end
        c_valid = '0;
        tick();
        tick();
    endtask

    initial begin
        vectors        = 0;
        miscompares    = 0;
        reset          = 1'b1;
        c_valid        = '0;
        c_addr         = '0;
        mem_read_ready = 1'b0;
        mem_read_data  = '0;
        test_reset();
        test_single();
        test_all_four();
        test_same_address();
        test_reset_mid_wait();
        test_hold_valid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/program_mem_controller.md
# program_mem_controller

Shared program-memory front end sitting directly upstream of every core's instruction fetcher and instruction cache. It accepts line-refill requests from `NUM_CONSUMERS` fetchers, arbitrates them round-robin onto a single external program-memory read channel, and returns the `READ_NUM`-word line to the granted fetcher. Optionally, it returns the same line to every other fetcher waiting on the same address.

## Interface
- `NUM_CONSUMERS`, default 4: number of fetchers served (≥2).
- `ADDR_BITS`, default 8: program memory address width.
- `DATA_BITS`, default 16: instruction word width.
- `READ_NUM`, default 4: words per line read (line = `READ_NUM*DATA_BITS` bits).

Ports:
- `clk`, input, 1: clock. One clock.
- `reset`, input, 1: synchronous, active-high reset.
- `consumer_read_valid`, input, `NUM_CONSUMERS`: per-fetcher request. Held high with a stable address until served.
- `consumer_read_address`, input, `NUM_CONSUMERS` × `ADDR_BITS`: per-fetcher line address.
- `consumer_read_ready`, output, `NUM_CONSUMERS`: per-fetcher one-cycle completion pulse.
- `consumer_read_data`, output, `NUM_CONSUMERS` × `READ_NUM*DATA_BITS`: line data. Valid while the matching ready is high.
- `mem_read_valid`, output, 1: external read request.
- `mem_read_address`, output, `ADDR_BITS`: external read address.
- `mem_read_ready`, input, 1: external completion. Data is valid in the same cycle.
- `mem_read_data`, input, `READ_NUM*DATA_BITS`: external line.

## Operation
- The FSM has four states: IDLE, WAITING, RELAYING, RELEASING.
- **IDLE**
  - If any `consumer_read_valid` is high, pick a consumer round-robin, starting at the index after the last granted one (index 0 after reset).
  - Latch the grant index and address.
  - Register `mem_read_valid`=1 and `mem_read_address`=latched address.
  - Go to WAITING.
- **WAITING**
  - Hold `mem_read_valid` and the address until `mem_read_ready`=1.
  - In that cycle: capture `mem_read_data` into the line register, clear `mem_read_valid`, build the serve mask, go to RELAYING.
- **RELAYING**
  - For exactly one cycle, drive `consumer_read_ready[i]`=1 for each i in the serve mask.
  - Drive `consumer_read_data[i]` = line register for the same i.
  - Go to RELEASING.
- **RELEASING**
  - Wait until `consumer_read_valid[i]`=0 for every i in the serve mask, then go to IDLE.
  - Prevents a still-high valid from being re-granted.
- Serve mask is the granted consumer only, except under the configuration macro (see Configuration).
- The round-robin pointer advances past the granted index only. Coalesced consumers do not move it.
- `consumer_read_data[i]` is zero when its ready is low.
- `mem_read_ready` outside WAITING is ignored.
- A consumer dropping valid during WAITING is not supported. The line is still delivered.

## Timing
- Reset values: `mem_read_valid`=0, `mem_read_address`=0, all `consumer_read_ready`=0, all `consumer_read_data`=0, state IDLE, pointer 0, line register 0.
- Request seen in IDLE at cycle t → `mem_read_valid` high at t+1.
- `mem_read_ready` at cycle m → `mem_read_valid` low at m+1, consumer ready pulse at m+1 (exactly one cycle).
- Minimum turnaround:
  - With zero-wait memory (ready at t+1): served at t+2.
  - The consumer drops valid at t+3.
  - IDLE at t+4, next grant at t+4.
- Reset is asserted mid-operation in any state: every output returns to its reset value on the next edge. The outstanding external read is abandoned, and no ready is issued for it.

## Configuration
- `PMEM_COALESCE_EN` defined:
  - In the `mem_read_ready` cycle, the serve mask also includes every consumer j with `consumer_read_valid[j]`=1 and `consumer_read_address[j]` equal to the latched address.
  - All of them receive the line in RELAYING.
  - All must drop valid before IDLE.
- Undefined: the serve mask is the granted consumer only. Same-address requesters are served by later separate reads.

## Structure
- Package `pmem_pkg`: state enum (`PMEM_IDLE`, `PMEM_WAITING`, `PMEM_RELAYING`, `PMEM_RELEASING`) and line-width localparam helpers.
- One sub-module `rr_arbiter`:
  - Parameter `N`.
  - Inputs: `req[N]`, `last_grant` index.
  - Outputs: `grant_valid`, `grant_index`.
  - Combinational priority rotation starting after `last_grant`.

## Test plan
- Single request, consumer 2 asks 0x10, memory ready 3 cycles after valid, data 0x1111_2222_3333_4444 → `mem_read_address`=0x10; `consumer_read_ready[2]` for one cycle with that data; other readies stay 0.
- All four consumers request distinct addresses in the same cycle after reset → grant order 0,1,2,3, each served once.
- Consumers 1 and 3 request 0x20 together → with `PMEM_COALESCE_EN`, one external read and both readies in the same cycle; without it, two external reads, consumer 1 then 3.
- Reset pulsed while in WAITING, then `mem_read_ready` arrives → no consumer ready, `mem_read_valid`=0, next request granted starting from consumer 0.
- Consumer holds valid 5 cycles after its ready → no new external read until it drops; then the next request issues.
- Zero-wait memory, back-to-back requests → ready at t+2, next `mem_read_valid` at t+5.
